regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the single-cycle datapath core: two combinational read ports, two synchronous write ports with a fixed collision priority, same-cycle write-to-read bypass, and an optional hardwired zero register. After reset, a sequencer clears the array one entry per cycle and reports completion on `ready`, so the storage itself carries no reset fan-out.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: address width; depth `DEPTH = 2**ADDR_W`.
- `ZERO_REG`, default 1: when 1, entry 0 always reads 0 and ignores writes.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `ra1` input ADDR_W: read address, port 1.
- `ra2` input ADDR_W: read address, port 2.
- `rd1` output DATA_W: read data, port 1 (combinational).
- `rd2` output DATA_W: read data, port 2 (combinational).
- `wa1` input ADDR_W: write address, port 1.
- `wd1` input DATA_W: write data, port 1.
- `we1` input 1: write enable, port 1.
- `wa2` input ADDR_W: write address, port 2.
- `wd2` input DATA_W: write data, port 2.
- `we2` input 1: write enable, port 2.
- `ready` output 1: registered; high when the clear sweep is done and the file accepts accesses.

## Operation
- **States:** two-state FSM, CLEAR and RUN, plus a clear pointer `ptr` of ADDR_W bits.
- **Reset (`rst_n` low at an edge):**
  - State becomes CLEAR, `ptr` is 0 and `ready` is 0.
  - Array contents are not touched on that edge.
- **CLEAR state:**
  - Each edge with `rst_n` high writes 0 to entry `ptr` and increments `ptr`.
  - On the edge that clears entry DEPTH-1, the state becomes RUN and `ready` becomes 1.
  - `we1` and `we2` are ignored.
  - `rd1` and `rd2` are forced to 0.
- **Reset mid-sweep:** the sweep restarts from entry 0. `ready` stays 0.
- **RUN state:**
  - `weN` high writes `wdN` to entry `waN` at the edge.
  - If both ports write the same address in one cycle, port 2 wins and port 1's data is discarded.
  - Writes to distinct addresses both commit.
  - RUN persists until `rst_n` is low.
- **Read, RUN state:** each port applies these rules in priority order.
  - If `ZERO_REG`=1 and `raN`=0, the output is 0.
  - Else, if `we2` is high and `wa2`=`raN`, the output is `wd2`.
  - Else, if `we1` is high and `wa1`=`raN`, the output is `wd1`.
  - Else, the output is the stored entry.
- **Zero register:** if `ZERO_REG`=1, writes to address 0 are dropped and are never bypassed. If `ZERO_REG`=0, entry 0 is an ordinary register.
- **Width rules:** addresses are full-range with no out-of-range case. Data is stored and returned unmodified at DATA_W bits.

## Timing
- **Write latency:** a write at edge k is visible from storage after edge k. It is also visible combinationally in cycle k through the bypass path.
- **Read latency:** zero cycles; `rd1` and `rd2` depend combinationally on the addresses, the write ports and the array.
- **`ready`:**
  - Rises exactly DEPTH edges after the first edge that samples `rst_n` high following a reset edge (32 edges with the defaults).
  - Reset value is 0.
- **Output values during reset and CLEAR:** `rd1`=`rd2`=0 and `ready`=0.
- **Power-up:** array contents before the sweep completes are undefined. No consumer may access the file before `ready` is 1.

## Test plan
- **Reset sweep:** hold `rst_n` low for 2 edges, then release. Require `ready`=0 for 31 edges and `ready`=1 after edge 32 (defaults). Require all 32 entries to read 0.
- **Basic write/read:** after `ready`, write 0xDEADBEEF to reg 5 via port 1, then read `ra1`=5. Require `rd1`=0xDEADBEEF the following cycle. Require the same value in the write cycle via bypass.
- **Write collision:** `we1`=`we2`=1, `wa1`=`wa2`=7, `wd1`=0x11, `wd2`=0x22. Require reg 7 = 0x22 afterwards. Require `rd1` with `ra1`=7 to show 0x22 in the same cycle.
- **Zero register:** with `ZERO_REG`=1, write 0xFFFFFFFF to reg 0 on both ports. Require `rd1`=`rd2`=0 in the write cycle and after it. Repeat with `ZERO_REG`=0 and require 0xFFFFFFFF.
- **Dual independent writes:** port 1 writes reg 3 = 0xA5A5A5A5 and port 2 writes reg 31 = 0x5A5A5A5A in the same cycle. Require both values on `rd1`/`rd2` after the edge.
- **Reset mid-sweep and writes in CLEAR:** assert `rst_n` low at sweep edge 10, then release. Require `ready` to rise 32 edges after release. Writes attempted during CLEAR (reg 4 = 0x1234) must leave reg 4 = 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational reads, two synchronous writes.
// A post-reset sweep clears the array so storage needs no reset fan-out.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa2,
  input  logic [DATA_W-1:0] wd2,
  input  logic              we2,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic run;
  logic clr;
  logic z1, z2;
  logic wen1, wen2;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    unique case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  assign run = rst_n && (state_q == RUN);
  assign clr = rst_n && (state_q == CLEAR);
  assign z1  = ZERO_REG && (wa1 == '0);
  assign z2  = ZERO_REG && (wa2 == '0);

  // Port 2 wins a same-address collision, so port 1 stands down.
  assign wen1 = run && we1 && !z1 && !(we2 && (wa2 == wa1));
  assign wen2 = run && we2 && !z2;

  always_ff @(posedge clk) begin
    if (clr) begin
      mem_q[ptr_q] <= '0;
    end
    if (wen1) begin
      mem_q[wa1] <= wd1;
    end
    if (wen2) begin
      mem_q[wa2] <= wd2;
    end
  end

  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];

  assign ra[0] = ra1;
  assign ra[1] = ra2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = '0;
      if (run) begin
        priority case (1'b1)
          ZERO_REG && (ra[p] == '0): rd[p] = '0;
          we2 && (wa2 == ra[p]):     rd[p] = wd2;
          we1 && (wa1 == ra[p]):     rd[p] = wd1;
          default:                   rd[p] = mem_q[ra[p]];
        endcase
      end
    end
  end

  assign rd1   = rd[0];
  assign rd2   = rd[1];
  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array model.
// Runs a ZERO_REG=1 and a ZERO_REG=0 instance side by side.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa1, wa2;
  logic [31:0] wd1, wd2;
  logic        we1, we2;
  logic [31:0] rd1_z, rd2_z, rd1_n, rd2_n;
  logic        rdy_z, rdy_n;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_z [32];
  logic [31:0] m_n [32];

  always #5 clk = ~clk;

  regfile_mp u_dut_z (
    .clk(clk), .rst_n(rst_n),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_z), .rd2(rd2_z),
    .wa1(wa1), .wd1(wd1), .we1(we1),
    .wa2(wa2), .wd2(wd2), .we2(we2),
    .ready(rdy_z)
  );

  regfile_mp #(.ZERO_REG(1'b0)) u_dut_n (
    .clk(clk), .rst_n(rst_n),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .wa1(wa1), .wd1(wd1), .we1(we1),
    .wa2(wa2), .wd2(wd2), .we2(we2),
    .ready(rdy_n)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input bit zr,
                                         input logic [4:0] a);
    if (zr && a == 5'd0) return 32'h0;
    if (we2 && wa2 == a) return wd2;
    if (we1 && wa1 == a) return wd1;
    return zr ? m_z[a] : m_n[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      m_z[i] = '0;
      m_n[i] = '0;
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic e1, input logic [4:0] a1,
                        input logic [31:0] d1, input logic e2,
                        input logic [4:0] a2, input logic [31:0] d2);
    we1 = e1; wa1 = a1; wd1 = d1;
    we2 = e2; wa2 = a2; wd2 = d2;
  endtask

  task automatic check_rd(input string tag);
    #1;
    chk({tag, "/z.rd1"}, rd1_z, ref_rd(1'b1, ra1));
    chk({tag, "/z.rd2"}, rd2_z, ref_rd(1'b1, ra2));
    chk({tag, "/n.rd1"}, rd1_n, ref_rd(1'b0, ra1));
    chk({tag, "/n.rd2"}, rd2_n, ref_rd(1'b0, ra2));
  endtask

  // Commit this cycle's writes in port order, so port 2 lands last.
  task automatic step();
    if (we1) begin
      m_n[wa1] = wd1;
      if (wa1 != 5'd0) m_z[wa1] = wd1;
    end
    if (we2) begin
      m_n[wa2] = wd2;
      if (wa2 != 5'd0) m_z[wa2] = wd2;
    end
    edge1();
  endtask

  // Called just after the first edge has been set up to sample rst_n high.
  task automatic sweep(input string tag);
    for (int i = 1; i <= 32; i++) begin
      edge1();
      chk({tag, "/ready.z"}, 32'(rdy_z), 32'(i == 32));
      chk({tag, "/ready.n"}, 32'(rdy_n), 32'(i == 32));
      if (i < 32) begin
        chk({tag, "/clr.rd1"}, rd1_z, 32'h0);
        chk({tag, "/clr.rd1n"}, rd1_n, 32'h0);
      end
    end
    clear_model();
  endtask

  initial begin
    rst_n = 1'b0;
    ra1 = '0; ra2 = '0;
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    clear_model();

    edge1();
    edge1();
    chk("rst/ready", 32'(rdy_z), 32'h0);
    chk("rst/rd1", rd1_z, 32'h0);
    chk("rst/rd2n", rd2_n, 32'h0);
    rst_n = 1'b1;
    sweep("sweep");

    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      chk("init.rd1", rd1_z, 32'h0);
      chk("init.rd2", rd2_z, 32'h0);
      chk("init.rd1n", rd1_n, 32'h0);
      chk("init.rd2n", rd2_n, 32'h0);
    end

    ra1 = 5'd5; ra2 = 5'd6;
    set_wr(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    #1;
    chk("basic/bypass", rd1_z, 32'hDEADBEEF);
    check_rd("basic/bypass");
    step();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("basic/stored", rd1_z, 32'hDEADBEEF);
    check_rd("basic/stored");

    ra1 = 5'd7; ra2 = 5'd7;
    set_wr(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    #1;
    chk("coll/bypass", rd1_z, 32'h22);
    check_rd("coll/bypass");
    step();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("coll/stored", rd1_z, 32'h22);
    chk("coll/stored.n", rd2_n, 32'h22);

    ra1 = 5'd0; ra2 = 5'd0;
    set_wr(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    chk("zero/byp.z1", rd1_z, 32'h0);
    chk("zero/byp.z2", rd2_z, 32'h0);
    chk("zero/byp.n1", rd1_n, 32'hFFFFFFFF);
    step();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("zero/st.z1", rd1_z, 32'h0);
    chk("zero/st.z2", rd2_z, 32'h0);
    chk("zero/st.n1", rd1_n, 32'hFFFFFFFF);
    chk("zero/st.n2", rd2_n, 32'hFFFFFFFF);

    ra1 = 5'd3; ra2 = 5'd31;
    set_wr(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd31, 32'h5A5A5A5A);
    step();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("dual/rd1", rd1_z, 32'hA5A5A5A5);
    chk("dual/rd2", rd2_z, 32'h5A5A5A5A);
    check_rd("dual");

    for (int n = 0; n < 400; n++) begin
      logic narrow;
      narrow = 1'($urandom);
      we1 = 1'($urandom);
      we2 = 1'($urandom);
      wa1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wa2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra2 = 5'($urandom);
      wd1 = $urandom;
      wd2 = $urandom;
      check_rd("rand");
      step();
    end
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    rst_n = 1'b0;
    edge1();
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) edge1();
    chk("mid/ready9", 32'(rdy_z), 32'h0);
    rst_n = 1'b0;
    edge1();
    rst_n = 1'b1;
    ra1 = 5'd4;
    set_wr(1'b1, 5'd4, 32'h1234, 1'b1, 5'd4, 32'h1234);
    sweep("mid");
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    ra2 = 5'd4;
    #1;
    chk("mid/reg4.z", rd1_z, 32'h0);
    chk("mid/reg4.n", rd2_n, 32'h0);
    check_rd("mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
